symbol_packetizer: RTL and testbench
====================================

SYMBOL_PACKETIZER -- requirements
Module: symbol_packetizer

Interface
REQ-001 The block SHALL have these parameters: PKT_WORDS, default 4, 16-bit words per full packet (range 1..8); FIFO_DEPTH, default 16, word buffer depth (power of 2); TIMEOUT, default 65535, idle clocks before a partial packet is flushed; SRC_ADDR, default 8'h11, packet Source field; DST_ADDR, default 8'hAA, packet Destination field.
REQ-002 Port ipClk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port ipReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port ipQAMBlock, input, 4 bits: demapped QAM symbol.
REQ-005 Port ipQAMBlockValid, input, 1 bit: single-cycle qualifier for ipQAMBlock.
REQ-006 Port ipSymAlign, input, 1 bit: pulse that discards any partial word and restarts nibble position 0.
REQ-007 Port opTxStream, output, UART_PACKET: byte stream to the UART transmitter (Valid, SoP, EoP, Length, Source, Destination, Data).
REQ-008 Port ipTxReady, input, 1 bit: UART transmitter can accept a byte.
REQ-009 Port opFIFO_Size, output, 5 bits (log2(FIFO_DEPTH)+1): current word count.
REQ-010 Port opOverflow, output, 1 bit: sticky flag, set when a completed word is dropped.

Function
REQ-011 The block SHALL assemble four valid nibbles LSB-first: 1st into [3:0], 2nd [7:4], 3rd [11:8], 4th [15:12].
REQ-012 On the 4th nibble it SHALL write the word into the FIFO on the next edge, and the nibble position SHALL return to 0.
REQ-013 ipSymAlign SHALL reset the nibble position to 0 and discard the partial word; if ipSymAlign and ipQAMBlockValid coincide, that nibble SHALL be taken as position 0.
REQ-014 If the FIFO is full when a word completes, the word SHALL be dropped, opOverflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-015 A FIFO write and a pop in the same cycle SHALL leave opFIFO_Size unchanged and both SHALL take effect; when full, a simultaneous pop SHALL make room, so the write is accepted.
REQ-016 The TX state machine SHALL have states Idle, SendLow, SendHigh.
REQ-017 Idle -> SendLow SHALL occur when opFIFO_Size >= PKT_WORDS; N = PKT_WORDS is latched.
REQ-018 Idle -> SendLow SHALL also occur when 0 < opFIFO_Size < PKT_WORDS and the idle counter reaches TIMEOUT; N = opFIFO_Size is latched.
REQ-019 The idle counter SHALL clear on every valid nibble, on every packet start, and while the FIFO is empty; it SHALL saturate and never wrap.
REQ-020 Every byte of a packet SHALL carry Length = 2*N, Source = SRC_ADDR, Destination = DST_ADDR.
REQ-021 SendLow SHALL present FIFO head [7:0] and SendHigh SHALL present FIFO head [15:8].
REQ-022 SoP SHALL be 1 only on the first byte; EoP SHALL be 1 only on the 2N-th byte.
REQ-023 Handshake: opTxStream.Valid SHALL be held with Data and flags stable until a cycle where Valid && ipTxReady (transfer).
REQ-024 Valid SHALL be deasserted the cycle after a transfer for at least one cycle.
REQ-025 Transfer in SendLow SHALL go to SendHigh.
REQ-026 Transfer in SendHigh SHALL pop the FIFO; then, if words sent == N, go to Idle, else go to SendLow.
REQ-027 Maximum throughput SHALL be one byte per two clocks; the first byte SHALL be valid 1 clock after the Idle exit decision.
REQ-028 Nibble intake and FIFO writes SHALL continue unaffected while a packet is in flight.

Reset
REQ-029 While ipReset = 0, regardless of clock: opTxStream.Valid = 0, SoP = 0, EoP = 0, Length = 0, Data = 0, Source = SRC_ADDR, Destination = DST_ADDR; FIFO emptied; opFIFO_Size = 0; opOverflow = 0; nibble position = 0; idle counter = 0; state = Idle.
REQ-030 Reset asserted mid-packet SHALL abort the packet with no EoP emitted; after release, the block SHALL restart from Idle with an empty FIFO.

Verification
REQ-031 Scenario: nibbles 4,3,2,1 then 8,7,6,5, C,B,A,9, 0,F,E,D with ipTxReady = 1 SHALL produce an 8-byte packet, bytes 34,12,78,56,BC,9A,F0,DE, Length = 8, SoP on byte 1, EoP on byte 8, Source = 11, Destination = AA.
REQ-032 Scenario: 6 nibbles then ipSymAlign, then 4 nibbles 1,1,1,1 SHALL yield FIFO word 16'h1111 and opFIFO_Size = 1.
REQ-033 Scenario: TIMEOUT = 20 with one word 16'hBEEF and no further nibbles SHALL emit a 2-byte packet EF,BE, Length = 2, SoP and EoP both set, about 20 clocks after the write.
REQ-034 Scenario: ipTxReady held 0 for 50 cycles mid-packet SHALL keep Valid = 1 with Data stable and emit no duplicate bytes after ready returns.
REQ-035 Scenario: 17 words pushed with ipTxReady = 0 and FIFO_DEPTH = 16 SHALL give opFIFO_Size = 16 and opOverflow = 1, and the packets SHALL contain the first 16 words in order.
REQ-036 Scenario: ipReset pulsed low after byte 3 of a packet SHALL give Valid = 0 immediately and opFIFO_Size = 0; the next 4 words SHALL produce a fresh packet starting with SoP.

Source files
------------

// File: rtl/symbol_packetizer.sv
// Symbol packetizer: packs 4-bit demapped QAM symbols into 16-bit words,
// buffers them in a small FIFO and ships them to a UART transmitter as
// byte packets (low byte first) with start/end markers and a length field.
//
// opTxStream is a flat 35-bit record, most significant field first:
//   [34]    Valid
//   [33]    SoP
//   [32]    EoP
//   [31:24] Length (bytes in the packet)
//   [23:16] Source
//   [15:8]  Destination
//   [7:0]   Data
module symbol_packetizer #(
    parameter int         PKT_WORDS  = 4,
    parameter int         FIFO_DEPTH = 16,
    parameter int         TIMEOUT    = 65535,
    parameter logic [7:0] SRC_ADDR   = 8'h11,
    parameter logic [7:0] DST_ADDR   = 8'hAA
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  logic [3:0]                  ipQAMBlock,
    input  logic                        ipQAMBlockValid,
    input  logic                        ipSymAlign,
    output logic [34:0]                 opTxStream,
    input  logic                        ipTxReady,
    output logic [$clog2(FIFO_DEPTH):0] opFIFO_Size,
    output logic                        opOverflow
);

    localparam int              AW          = $clog2(FIFO_DEPTH);
    localparam int              CW          = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]     DEPTH_VAL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]     PKT_VAL     = (AW + 1)'(PKT_WORDS);
    localparam logic [CW-1:0]   TIMEOUT_VAL = CW'(TIMEOUT);
    localparam logic [3:0]      PKT_N       = 4'(PKT_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        SEND_LOW,
        SEND_HIGH
    } tx_state_t;

    // Nibble assembly
    logic [1:0]  nib_pos;
    logic [11:0] partial;
    logic [15:0] word_reg;
    logic        word_pending;

    // Word FIFO
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          full;
    logic          push;
    logic          pop;
    logic [15:0]   head;

    // Idle timer and packet launch
    logic [CW-1:0] idle_cnt;
    logic          start_full;
    logic          start_timeout;
    logic          start;
    logic [3:0]    start_n;

    // Transmit side
    tx_state_t   state;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic [7:0]  tx_len;
    logic [7:0]  tx_data;
    logic [3:0]  pkt_words;
    logic [3:0]  sent;

    assign full          = (count == DEPTH_VAL);
    assign pop           = (state == SEND_HIGH) && tx_valid && ipTxReady;
    assign push          = word_pending && (!full || pop);
    assign head          = mem[rd_ptr];
    assign start_full    = (state == IDLE) && (count >= PKT_VAL);
    assign start_timeout = (state == IDLE) && (count != '0) && (count < PKT_VAL)
                           && (idle_cnt == TIMEOUT_VAL);
    assign start         = start_full || start_timeout;
    assign start_n       = start_full ? PKT_N : 4'(count);

    assign opTxStream  = {tx_valid, tx_sop, tx_eop, tx_len, SRC_ADDR, DST_ADDR, tx_data};
    assign opFIFO_Size = count;
    assign opOverflow  = overflow;

    // Collect nibbles LSB-first; an align pulse restarts at position 0 and a
    // coincident valid nibble becomes the new position 0.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            nib_pos      <= 2'd0;
            partial      <= 12'h000;
            word_reg     <= 16'h0000;
            word_pending <= 1'b0;
        end else begin
            word_pending <= 1'b0;
            if (ipQAMBlockValid) begin
                if (ipSymAlign) begin
                    partial <= {8'h00, ipQAMBlock};
                    nib_pos <= 2'd1;
                end else begin
                    case (nib_pos)
                        2'd0: begin
                            partial[3:0] <= ipQAMBlock;
                            nib_pos      <= 2'd1;
                        end
                        2'd1: begin
                            partial[7:4] <= ipQAMBlock;
                            nib_pos      <= 2'd2;
                        end
                        2'd2: begin
                            partial[11:8] <= ipQAMBlock;
                            nib_pos       <= 2'd3;
                        end
                        default: begin
                            word_reg     <= {ipQAMBlock, partial};
                            word_pending <= 1'b1;
                            nib_pos      <= 2'd0;
                        end
                    endcase
                end
            end else if (ipSymAlign) begin
                partial <= 12'h000;
                nib_pos <= 2'd0;
            end
        end
    end

    // FIFO storage; emptiness is defined by the pointers, so no reset here.
    always_ff @(posedge ipClk) begin
        if (push) begin
            mem[wr_ptr] <= word_reg;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (word_pending && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Saturating idle timer used to flush a partial packet when symbols stop.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            idle_cnt <= '0;
        end else if (ipQAMBlockValid || start || (count == '0)) begin
            idle_cnt <= '0;
        end else if ((state == IDLE) && (idle_cnt != TIMEOUT_VAL)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Transmit FSM: one byte per handshake, with a one-cycle Valid gap after
    // every transfer so the next byte is taken from the updated FIFO head.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state     <= IDLE;
            tx_valid  <= 1'b0;
            tx_sop    <= 1'b0;
            tx_eop    <= 1'b0;
            tx_len    <= 8'h00;
            tx_data   <= 8'h00;
            pkt_words <= 4'd0;
            sent      <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pkt_words <= start_n;
                        tx_len    <= {3'd0, start_n, 1'b0};
                        sent      <= 4'd0;
                        tx_valid  <= 1'b1;
                        tx_sop    <= 1'b1;
                        tx_eop    <= 1'b0;
                        tx_data   <= head[7:0];
                        state     <= SEND_LOW;
                    end
                end
                SEND_LOW: begin
                    if (tx_valid && ipTxReady) begin
                        tx_valid <= 1'b0;
                        tx_sop   <= 1'b0;
                        state    <= SEND_HIGH;
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_sop   <= 1'b0;
                        tx_eop   <= 1'b0;
                        tx_data  <= head[7:0];
                    end
                end
                SEND_HIGH: begin
                    if (tx_valid && ipTxReady) begin
                        tx_valid <= 1'b0;
                        tx_eop   <= 1'b0;
                        sent     <= sent + 4'd1;
                        state    <= ((sent + 4'd1) == pkt_words) ? IDLE : SEND_LOW;
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_sop   <= 1'b0;
                        tx_eop   <= ((sent + 4'd1) == pkt_words);
                        tx_data  <= head[15:8];
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_packetizer.sv
// Self-checking bench for symbol_packetizer. A queue-based reference model
// turns the driven nibble stream into words, and packets are predicted as
// consecutive chunks of PKT_WORDS words with a final short chunk flushed by
// the idle timeout. Observed byte transfers are collected by a monitor.
module tb_symbol_packetizer;

    localparam int PKT_WORDS  = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int TIMEOUT    = 20;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic [3:0]  ipQAMBlock;
    logic        ipQAMBlockValid;
    logic        ipSymAlign;
    logic [34:0] opTxStream;
    logic        ipTxReady = 1'b0;
    logic [4:0]  opFIFO_Size;
    logic        opOverflow;

    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic [7:0]  tx_len;
    logic [7:0]  tx_src;
    logic [7:0]  tx_dst;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;

    logic [3:0]  partial_q [$];
    logic [15:0] model_words [$];
    logic [33:0] obs_q [$];

    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [33:0] prev_rec = '0;

    logic [7:0]  s031_exp [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    logic [3:0]  s031_nibs [16] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5,
                                    4'hC, 4'hB, 4'hA, 4'h9, 4'h0, 4'hF, 4'hE, 4'hD};

    assign tx_valid = opTxStream[34];
    assign tx_sop   = opTxStream[33];
    assign tx_eop   = opTxStream[32];
    assign tx_len   = opTxStream[31:24];
    assign tx_src   = opTxStream[23:16];
    assign tx_dst   = opTxStream[15:8];
    assign tx_data  = opTxStream[7:0];

    symbol_packetizer #(
        .PKT_WORDS  (PKT_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .ipClk           (ipClk),
        .ipReset         (ipReset),
        .ipQAMBlock      (ipQAMBlock),
        .ipQAMBlockValid (ipQAMBlockValid),
        .ipSymAlign      (ipSymAlign),
        .opTxStream      (opTxStream),
        .ipTxReady       (ipTxReady),
        .opFIFO_Size     (opFIFO_Size),
        .opOverflow      (opOverflow)
    );

    // 100 MHz clock
    always #5 ipClk = ~ipClk;

    // Drive the UART ready line: forced low, forced high or random per cycle.
    always @(posedge ipClk) begin
        #2;
        case (ready_mode)
            0:       ipTxReady = 1'b0;
            1:       ipTxReady = 1'b1;
            default: ipTxReady = 1'($urandom_range(0, 1));
        endcase
    end

    // Watch the byte stream: stalled bytes must stay put, a transfer must be
    // followed by a Valid gap, and every transfer is logged for comparison.
    always @(negedge ipClk) begin
        if (!ipReset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                checkOutput("hold_valid", 64'(tx_valid), 64'(1));
                checkOutput("hold_fields", 64'(opTxStream[33:0]), 64'(prev_rec));
            end
            if (prev_valid && prev_ready) begin
                checkOutput("gap_after_transfer", 64'(tx_valid), 64'(0));
            end
            if (tx_valid && ipTxReady) begin
                obs_q.push_back(opTxStream[33:0]);
            end
            prev_valid = tx_valid;
            prev_ready = ipTxReady;
            prev_rec   = opTxStream[33:0];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of input drive; the model assembles words from the same stream.
    task automatic applyStimulus(input logic [3:0] nib, input logic valid, input logic align);
        @(posedge ipClk);
        #2;
        ipQAMBlock      = nib;
        ipQAMBlockValid = valid;
        ipSymAlign      = align;
        if (align) begin
            partial_q.delete();
        end
        if (valid) begin
            partial_q.push_back(nib);
            if (partial_q.size() == 4) begin
                model_words.push_back({partial_q[3], partial_q[2], partial_q[1], partial_q[0]});
                partial_q.delete();
            end
        end
    endtask

    task automatic feed_word(input logic [15:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[4*i +: 4], 1'b1, 1'b0);
            repeat ($urandom_range(0, gap_max)) applyStimulus(4'h0, 1'b0, 1'b0);
        end
    endtask

    // Wait until the FIFO is empty and no byte is offered for well past the
    // flush timeout, so every packet of the round has been sent.
    task automatic wait_idle();
        int quiet;
        int cyc;
        quiet = 0;
        cyc   = 0;
        applyStimulus(4'h0, 1'b0, 1'b0);
        while (quiet < TIMEOUT + 15 && cyc < 4000) begin
            @(negedge ipClk);
            #1;
            cyc++;
            if (opFIFO_Size == 5'd0 && !tx_valid) quiet++;
            else quiet = 0;
        end
        checkOutput("drain_in_time", 64'(quiet >= TIMEOUT + 15), 64'(1));
    endtask

    task automatic wait_obs(input int n);
        int cyc;
        cyc = 0;
        while (obs_q.size() < n && cyc < 1000) begin
            @(negedge ipClk);
            #1;
            cyc++;
        end
        checkOutput("bytes_arrive_in_time", 64'(obs_q.size() >= n), 64'(1));
    endtask

    // Predict the packet stream for a list of words and compare it with the log.
    task automatic checkPackets(input logic [15:0] words [$]);
        int total;
        int idx;
        int b;
        int n;
        logic [33:0] lo;
        logic [33:0] hi;
        logic [7:0]  len8;
        total = words.size();
        idx   = 0;
        b     = 0;
        checkOutput("byte_count", 64'(obs_q.size()), 64'(2 * total));
        while (idx < total) begin
            n    = (total - idx >= PKT_WORDS) ? PKT_WORDS : total - idx;
            len8 = 8'(2 * n);
            for (int j = 0; j < n; j++) begin
                lo = {(j == 0), 1'b0, len8, 8'h11, 8'hAA, words[idx + j][7:0]};
                hi = {1'b0, (j == n - 1), len8, 8'h11, 8'hAA, words[idx + j][15:8]};
                checkOutput($sformatf("pkt_byte%0d", b), (b < obs_q.size()) ? 64'(obs_q[b]) : 64'(0), 64'(lo));
                b++;
                checkOutput($sformatf("pkt_byte%0d", b), (b < obs_q.size()) ? 64'(obs_q[b]) : 64'(0), 64'(hi));
                b++;
            end
            idx += n;
        end
        obs_q.delete();
    endtask

    // Directed scenarios followed by randomized rounds.
    initial begin
        int lat;
        int cyc;
        int any_eop;
        logic [15:0] first16 [$];
        logic [34:0] held;

        ipReset         = 1'b1;
        ipQAMBlock      = 4'h0;
        ipQAMBlockValid = 1'b0;
        ipSymAlign      = 1'b0;
        #1 ipReset = 1'b0;
        #2;
        $display("[TB] reset state");
        checkOutput("rst_valid", 64'(tx_valid), 64'(0));
        checkOutput("rst_sop", 64'(tx_sop), 64'(0));
        checkOutput("rst_eop", 64'(tx_eop), 64'(0));
        checkOutput("rst_len", 64'(tx_len), 64'(0));
        checkOutput("rst_data", 64'(tx_data), 64'(0));
        checkOutput("rst_src", 64'(tx_src), 64'h11);
        checkOutput("rst_dst", 64'(tx_dst), 64'hAA);
        checkOutput("rst_size", 64'(opFIFO_Size), 64'(0));
        checkOutput("rst_overflow", 64'(opOverflow), 64'(0));
        repeat (3) @(negedge ipClk);
        ipReset = 1'b1;

        $display("[TB] four-word packet, ready high");
        ready_mode = 1;
        for (int i = 0; i < 16; i++) applyStimulus(s031_nibs[i], 1'b1, 1'b0);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("s031_byte%0d", i),
                        (i < obs_q.size()) ? 64'(obs_q[i][7:0]) : 64'hFFFF, 64'(s031_exp[i]));
        end
        checkPackets(model_words);
        model_words.delete();

        $display("[TB] symbol realignment");
        applyStimulus(4'h5, 1'b1, 1'b0);
        applyStimulus(4'h6, 1'b1, 1'b0);
        applyStimulus(4'h7, 1'b1, 1'b0);
        applyStimulus(4'h8, 1'b1, 1'b0);
        applyStimulus(4'h9, 1'b1, 1'b0);
        applyStimulus(4'hA, 1'b1, 1'b0);
        wait_idle();
        checkPackets(model_words);
        model_words.delete();
        applyStimulus(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(4'h1, 1'b1, 1'b0);
        applyStimulus(4'h0, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b0, 1'b0);
        @(negedge ipClk);
        #1;
        checkOutput("s032_size", 64'(opFIFO_Size), 64'(1));
        wait_idle();
        checkOutput("s032_word", (obs_q.size() >= 2) ? 64'({obs_q[1][7:0], obs_q[0][7:0]}) : 64'(0), 64'h1111);
        checkPackets(model_words);
        model_words.delete();

        $display("[TB] timeout flush of a single word");
        feed_word(16'hBEEF, 0);
        applyStimulus(4'h0, 1'b0, 1'b0);
        cyc = 0;
        while (opFIFO_Size != 5'd1 && cyc < 10) begin
            @(negedge ipClk);
            #1;
            cyc++;
        end
        lat = 0;
        while (!tx_valid && lat < 100) begin
            @(negedge ipClk);
            #1;
            lat++;
        end
        checkOutput("s033_latency_window", 64'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 64'(1));
        wait_idle();
        checkOutput("s033_bytes", (obs_q.size() >= 2) ? 64'({obs_q[0][7:0], obs_q[1][7:0]}) : 64'(0), 64'hEFBE);
        checkOutput("s033_flags", (obs_q.size() >= 2) ? 64'({obs_q[0][33], obs_q[1][32]}) : 64'(0), 64'b11);
        checkPackets(model_words);
        model_words.delete();

        $display("[TB] ready stall mid-packet");
        ready_mode = 1;
        for (int i = 0; i < 4; i++) feed_word(16'($urandom), 1);
        wait_obs(3);
        ready_mode = 0;
        @(negedge ipClk);
        @(negedge ipClk);
        #1;
        held = opTxStream;
        checkOutput("s034_byte4", 64'(held[7:0]), 64'(model_words[1][15:8]));
        repeat (50) @(negedge ipClk);
        #1;
        checkOutput("s034_still_valid", 64'(tx_valid), 64'(1));
        checkOutput("s034_stable", 64'(opTxStream), 64'(held));
        ready_mode = 1;
        wait_idle();
        checkPackets(model_words);
        model_words.delete();

        $display("[TB] overflow with ready low");
        ready_mode = 0;
        repeat (2) applyStimulus(4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) feed_word(16'($urandom), 0);
        repeat (3) applyStimulus(4'h0, 1'b0, 1'b0);
        @(negedge ipClk);
        #1;
        checkOutput("s035_size", 64'(opFIFO_Size), 64'(16));
        checkOutput("s035_overflow", 64'(opOverflow), 64'(1));
        ready_mode = 2;
        wait_idle();
        first16 = model_words[0:15];
        checkPackets(first16);
        checkOutput("s035_overflow_sticky", 64'(opOverflow), 64'(1));
        model_words.delete();

        $display("[TB] reset mid-packet");
        ready_mode = 1;
        for (int i = 0; i < 4; i++) feed_word(16'($urandom), 0);
        wait_obs(3);
        ready_mode = 0;
        @(negedge ipClk);
        #1;
        ipReset = 1'b0;
        #1;
        checkOutput("s036_valid", 64'(tx_valid), 64'(0));
        checkOutput("s036_size", 64'(opFIFO_Size), 64'(0));
        checkOutput("s036_overflow", 64'(opOverflow), 64'(0));
        any_eop = 0;
        foreach (obs_q[i]) if (obs_q[i][32]) any_eop = 1;
        checkOutput("s036_no_eop", 64'(any_eop), 64'(0));
        checkOutput("s036_bytes_before", 64'(obs_q.size()), 64'(3));
        repeat (2) @(negedge ipClk);
        ipQAMBlockValid = 1'b0;
        ipSymAlign      = 1'b0;
        ipReset         = 1'b1;
        obs_q.delete();
        model_words.delete();
        partial_q.delete();
        ready_mode = 2;
        for (int i = 0; i < 4; i++) feed_word(16'($urandom), 1);
        wait_idle();
        checkOutput("s036_fresh_sop", (obs_q.size() > 0) ? 64'(obs_q[0][33]) : 64'(0), 64'(1));
        checkPackets(model_words);
        model_words.delete();

        $display("[TB] randomized rounds");
        ready_mode = 2;
        for (int r = 0; r < 20; r++) begin
            int nibs;
            nibs = 4 * $urandom_range(1, 9) + $urandom_range(0, 3);
            for (int k = 0; k < nibs; k++) begin
                applyStimulus(4'($urandom), 1'b1, 1'($urandom_range(0, 19) == 0));
                repeat ($urandom_range(0, 3)) begin
                    applyStimulus(4'h0, 1'b0, 1'($urandom_range(0, 29) == 0));
                end
            end
            wait_idle();
            checkPackets(model_words);
            model_words.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
